// File: rtl/fifo_rd_pkg.sv
// Shared defaults and helpers for the FIFO read-side byte packer.
package fifo_rd_pkg;

  localparam int unsigned DW_DEFAULT    = 8;
  localparam int unsigned LANES_DEFAULT = 4;
  localparam int unsigned MAX_LANES     = 32;

  // Mask with the lowest `count` bits set; callers truncate to their lane count.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned count);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output register for the packed-word valid/ready stream.
module pack_out_reg
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned LANES = LANES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DW*LANES-1:0]   load_data,
  input  logic [LANES-1:0]      load_keep,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DW*LANES-1:0]   m_data,
  output logic [LANES-1:0]      m_keep,
  output logic                  load_ok_c
);

  // A new word may enter when the register is empty or is draining this edge.
  assign load_ok_c = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_keep  <= load_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_pack.sv
// Pops bytes from the async FIFO read port and packs them little-endian into
// LANES-wide words on a valid/ready stream; flush emits a partial word.
module fifo_rd_pack
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned LANES = LANES_DEFAULT
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  empty,
  output logic                  rinc,
  input  logic [DW-1:0]         rdata,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DW*LANES-1:0]   m_data,
  output logic [LANES-1:0]      m_keep,
  input  logic                  m_ready,
  output logic                  busy
);

  localparam int unsigned OW = DW * LANES;
  localparam int unsigned CW = $clog2(LANES + 1);

  logic [LANES-1:0][DW-1:0] acc;
  logic [LANES-1:0][DW-1:0] word_c;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_n;
  logic [CW-1:0]            fill_c;
  logic                     rd_vld;
  logic                     flush_req;
  logic                     flush_req_n;
  logic                     run;
  logic                     busy_n;
  logic                     load_c;
  logic                     load_ok_c;
  logic [LANES-1:0]         load_keep_c;
  logic [OW-1:0]            load_data_c;

  // Accumulator contents including the byte landing this cycle.
  always_comb begin
    word_c = acc;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (rd_vld && (cnt == CW'(i))) word_c[i] = rdata;
    end
  end

  // Word completion, flush completion and pop control.
  always_comb begin
    cnt_n       = cnt;
    flush_req_n = flush_req;
    load_c      = 1'b0;
    load_keep_c = '0;
    fill_c      = cnt + CW'(rd_vld);

    if (fill_c == CW'(LANES)) begin
      if (load_ok_c) begin
        load_c      = 1'b1;
        load_keep_c = '1;
        cnt_n       = '0;
        if (flush_req && !rd_vld) flush_req_n = 1'b0;
      end else begin
        cnt_n = fill_c;
      end
    end else if (flush_req && !rd_vld) begin
      if (cnt == '0) begin
        flush_req_n = 1'b0;
      end else if (load_ok_c) begin
        load_c      = 1'b1;
        load_keep_c = LANES'(keep_mask(32'(cnt)));
        cnt_n       = '0;
        flush_req_n = 1'b0;
      end
    end else begin
      cnt_n = fill_c;
    end

    if (flush && !flush_req) flush_req_n = 1'b1;

    rinc   = run && !empty && !flush_req && ((fill_c != CW'(LANES)) || load_ok_c);
    busy_n = flush_req_n || (cnt_n != '0) || rinc;
  end

  // Unused lanes of a partial word are driven as zero.
  always_comb begin
    load_data_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      load_data_c[i*DW +: DW] = load_keep_c[i] ? word_c[i] : '0;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      rd_vld    <= 1'b0;
      flush_req <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (rd_vld) acc <= word_c;
      cnt       <= cnt_n;
      rd_vld    <= rinc;
      flush_req <= flush_req_n;
      run       <= 1'b1;
      busy      <= busy_n;
    end
  end

  pack_out_reg #(
    .DW    (DW),
    .LANES (LANES)
  ) u_out (
    .clk       (rclk),
    .rst_n     (rst_n),
    .load      (load_c),
    .load_data (load_data_c),
    .load_keep (load_keep_c),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .load_ok_c (load_ok_c)
  );

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack with a small FIFO read-port model.
module tb_fifo_rd_pack;

  logic        rclk = 1'b0;
  logic        rst_n;
  logic        empty;
  logic        rinc;
  logic [7:0]  rdata;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  int          wptr = 0;
  int          rptr = 0;
  logic [31:0] got_data [$];
  logic [3:0]  got_keep [$];

  fifo_rd_pack dut (
    .rclk    (rclk),
    .rst_n   (rst_n),
    .empty   (empty),
    .rinc    (rinc),
    .rdata   (rdata),
    .flush   (flush),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_ready (m_ready),
    .busy    (busy)
  );

  always #5 rclk = ~rclk;

  // FIFO read port: data appears the cycle after an accepted pop
  assign empty = (wptr == rptr);
  always @(posedge rclk) begin
    if (rinc && !empty) begin
      rdata <= mem[rptr];
      rptr  <= rptr + 1;
    end
  end

  always @(posedge rclk) begin
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_keep.push_back(m_keep);
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (2) @(negedge rclk);
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0", rinc); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_m_keep: got %h expected 0", m_keep); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stream;
    int base, run, max_run, highs;
    base = got_data.size(); run = 0; max_run = 0; highs = 0;
    m_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (i == 0) begin
        checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL first_rinc: got %b expected 1", rinc); end
      end
      if (rinc === 1'b1) begin
        run++; highs++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    checks++; if (max_run != 8) begin errors++; $display("FAIL stream_rinc_run: got %0d expected 8", max_run); end
    checks++; if (highs != 8) begin errors++; $display("FAIL stream_rinc_total: got %0d expected 8", highs); end
    checks++;
    if (got_data.size() - base != 2) begin
      errors++; $display("FAIL stream_words: got %0d expected 2", got_data.size() - base);
    end else begin
      checks++; if (got_data[base] !== 32'h04030201) begin errors++; $display("FAIL stream_w0_data: got %h expected 04030201", got_data[base]); end
      checks++; if (got_keep[base] !== 4'hF) begin errors++; $display("FAIL stream_w0_keep: got %h expected f", got_keep[base]); end
      checks++; if (got_data[base+1] !== 32'h08070605) begin errors++; $display("FAIL stream_w1_data: got %h expected 08070605", got_data[base+1]); end
      checks++; if (got_keep[base+1] !== 4'hF) begin errors++; $display("FAIL stream_w1_keep: got %h expected f", got_keep[base+1]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure;
    int base;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h13121110; exp_w[1] = 32'h17161514; exp_w[2] = 32'h1B1A1918;
    base = got_data.size();
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
    repeat (20) @(negedge rclk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== exp_w[0]) begin errors++; $display("FAIL bp_held_data: got %h expected %h", m_data, exp_w[0]); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc_stalled: got %b expected 0", rinc); end
    checks++; if (wptr - rptr != 4) begin errors++; $display("FAIL bp_fifo_level: got %0d expected 4", wptr - rptr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b expected 1", busy); end
    m_ready = 1'b1;
    repeat (20) @(negedge rclk);
    checks++;
    if (got_data.size() - base != 3) begin
      errors++; $display("FAIL bp_words: got %0d expected 3", got_data.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_data[base+i] !== exp_w[i]) begin errors++; $display("FAIL bp_w%0d_data: got %h expected %h", i, got_data[base+i], exp_w[i]); end
        checks++; if (got_keep[base+i] !== 4'hF) begin errors++; $display("FAIL bp_w%0d_keep: got %h expected f", i, got_keep[base+i]); end
      end
    end
    checks++; if (wptr - rptr != 0) begin errors++; $display("FAIL bp_fifo_drained: got %0d expected 0", wptr - rptr); end
  endtask

  task automatic test_partial_flush;
    int base;
    base = got_data.size();
    push(8'hAA); push(8'hBB);
    repeat (6) @(negedge rclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pf_busy_holding: got %b expected 1", busy); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pf_no_early_word: got %b expected 0", m_valid); end
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    repeat (6) @(negedge rclk);
    checks++;
    if (got_data.size() - base != 1) begin
      errors++; $display("FAIL pf_words: got %0d expected 1", got_data.size() - base);
    end else begin
      checks++; if (got_data[base] !== 32'h0000BBAA) begin errors++; $display("FAIL pf_data: got %h expected 0000bbaa", got_data[base]); end
      checks++; if (got_keep[base] !== 4'b0011) begin errors++; $display("FAIL pf_keep: got %b expected 0011", got_keep[base]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pf_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_flush_empty;
    int base, highs, vals;
    base = got_data.size(); highs = 0; vals = 0;
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) highs++;
      if (m_valid === 1'b1) vals++;
      @(negedge rclk);
    end
    checks++; if (highs != 1) begin errors++; $display("FAIL fe_busy_cycles: got %0d expected 1", highs); end
    checks++; if (vals != 0) begin errors++; $display("FAIL fe_m_valid_cycles: got %0d expected 0", vals); end
    checks++; if (got_data.size() != base) begin errors++; $display("FAIL fe_words: got %0d expected 0", got_data.size() - base); end
  endtask

  task automatic test_reset_pop;
    int base;
    base = got_data.size();
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    @(negedge rclk);
    rst_n = 1'b0;
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL rp_rinc: got %b expected 0", rinc); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rp_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL rp_m_keep: got %h expected 0", m_keep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rp_busy: got %b expected 0", busy); end
    repeat (2) @(negedge rclk);
    rst_n = 1'b1;
    repeat (12) @(negedge rclk);
    checks++;
    if (got_data.size() - base != 1) begin
      errors++; $display("FAIL rp_words: got %0d expected 1", got_data.size() - base);
    end else begin
      checks++; if (got_data[base] !== 32'h35343332) begin errors++; $display("FAIL rp_data: got %h expected 35343332", got_data[base]); end
      checks++; if (got_keep[base] !== 4'hF) begin errors++; $display("FAIL rp_keep: got %h expected f", got_keep[base]); end
    end
    checks++; if (wptr - rptr != 0) begin errors++; $display("FAIL rp_fifo_level: got %0d expected 0", wptr - rptr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_partial_flush();
    test_flush_empty();
    test_reset_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
